execute_stage: RTL
==================

// Module: execute_stage
// PURPOSE
//  EX stage of the 5-stage pipelined RV32I core. Holds the ID/EX pipeline register and the
//  operand-forwarding muxes. Runs the ALU on the 4-bit ALU control code from the ALU decoder,
//  resolves branch/jump, and registers results into EX/MEM.
//  Sits between decode/ALU-decoder (upstream) and the memory stage (downstream).
// PARAMETERS
//  XLEN    32  datapath width
//  RADDR_W 5   register-file address width
// PORTS
//  clk            in  1       rising-edge clock
//  reset          in  1       synchronous, active-high reset
//  stall_e        in  1       hold ID/EX contents (from hazard unit)
//  flush_e        in  1       load bubble into ID/EX (from hazard unit)
//  rd1_d,rd2_d    in  XLEN    register operands from decode
//  imm_ext_d      in  XLEN    sign-extended immediate
//  pc_d,pc4_d     in  XLEN    PC and PC+4 of the decode instruction
//  rs1_d,rs2_d,rd_d in RADDR_W source/dest register indices
//  alu_control_d  in  4       ALU decoder output
//  alu_src_d      in  1       1: operand B = immediate
//  reg_write_d, mem_write_d, branch_d, jump_d  in 1  control bits
//  result_src_d   in  2       writeback select, passed through
//  forward_a_e, forward_b_e  in 2  00 reg, 01 result_w, 10 alu_result_m, 11 reserved (= 00)
//  result_w       in  XLEN    writeback-stage result for forwarding
//  rs1_e,rs2_e,rd_e out RADDR_W  EX-stage indices for hazard unit
//  pc_src_e       out 1       redirect fetch (combinational from EX register)
//  pc_target_e    out XLEN    pc_e + imm_e (combinational)
//  alu_result_m, write_data_m, pc4_m  out XLEN  EX/MEM data
//  rd_m           out RADDR_W
//  reg_write_m, mem_write_m  out 1
//  result_src_m   out 2
//  illegal_alu_m  out 1       ALU control code was unsupported
// BEHAVIOUR
//  - Reset: clk and reset are one clock and a synchronous active-high reset. Every ID/EX and
//    EX/MEM field clears to 0 on the edge where reset=1. All outputs read 0 after that edge.
//  - ID/EX update priority per edge: reset > flush_e > stall_e > load.
//    Bubble = all fields 0; alu_control 0000 is ADD. stall_e holds every field.
//  - EX/MEM loads every edge (no stall). Reset clears it.
//  - Latency: decode inputs at edge N feed EX during cycle N+1. Results appear on *_m after edge N+2.
//  - Operand A = fwd(forward_a_e, rd1_e). Forwarded B = fwd(forward_b_e, rd2_e).
//    Operand B = alu_src_e ? imm_e : forwarded B. write_data_m captures forwarded B, never the immediate.
//  - ALU codes: 0000 add; 0001 sub; 0010 and; 0011 or; 0101 slt (signed, result 0/1 zero-extended).
//    Wraps modulo 2^XLEN, no overflow flag.
//  - Any other code (incl. 1111): result 0, illegal_alu_m=1, reg_write_m and mem_write_m forced 0.
//  - zero = (ALU result == 0). pc_src_e = jump_e | (branch_e & zero) (beq only).
//    Forced 0 when the EX register holds a bubble.
//  - stall_e and flush_e both high: flush wins.
//  - reset asserted mid-stream: instruction in flight is discarded with no partial M-stage write.
// STRUCTURE
//  - Shared header riscv_defs.vh: ALU_ADD/SUB/AND/OR/SLT codes, FWD_REG/FWD_W/FWD_M encodings,
//    XLEN default.
//  - One sub-module alu_core (combinational: a, b, alu_control -> result, zero, illegal).
//  - Pipeline registers and forwarding muxes stay in execute_stage.
// TESTING
//  1. reset=1 for 2 cycles, then release -> every *_m output 0 and pc_src_e=0.
//  2. rd1=5, rd2=7, ctrl 0000, reg_write=1, rd=3 -> after 2 edges alu_result_m=12, rd_m=3, reg_write_m=1.
//     Same operands with ctrl 0001 -> 0xFFFFFFFE. ctrl 0101 with rd1=-1, rd2=1 -> 1.
//  3. Forwarding: forward_a_e=10 with alu_result_m=0x100, and forward_b_e=01 with result_w=0x20,
//     ctrl 0000, alu_src=0 -> next alu_result_m=0x120, write_data_m=0x20.
//  4. beq: branch_d=1, ctrl 0001, rd1=rd2=9, pc_d=0x40, imm=0x10 -> in EX cycle pc_src_e=1,
//     pc_target_e=0x50. With rd2=8 -> pc_src_e=0.
//  5. stall_e=1 for 2 cycles while decode inputs change -> rd_e and alu_result_m repeat the held
//     instruction. Assert flush_e with stall_e -> bubble: reg_write_m=0, mem_write_m=0.
//  6. ctrl 1111 with reg_write_d=1, mem_write_d=1 -> illegal_alu_m=1, alu_result_m=0,
//     reg_write_m=0, mem_write_m=0.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the RV32I execute stage: ALU control codes, forwarding selects
// and default datapath widths.
package execute_stage_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_SLT = 4'b0101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/execute_stage_alu_core.sv
// Combinational RV32I ALU subset (add/sub/and/or/slt); unsupported codes yield 0 and
// raise illegal.
module alu_core
    import execute_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_control,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_op_e'(alu_control))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline: ID/EX register, operand forwarding, ALU,
// branch/jump resolution and the EX/MEM register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_e,
    input  logic               flush_e,
    input  logic [XLEN-1:0]    rd1_d,
    input  logic [XLEN-1:0]    rd2_d,
    input  logic [XLEN-1:0]    imm_ext_d,
    input  logic [XLEN-1:0]    pc_d,
    input  logic [XLEN-1:0]    pc4_d,
    input  logic [RADDR_W-1:0] rs1_d,
    input  logic [RADDR_W-1:0] rs2_d,
    input  logic [RADDR_W-1:0] rd_d,
    input  logic [3:0]         alu_control_d,
    input  logic               alu_src_d,
    input  logic               reg_write_d,
    input  logic               mem_write_d,
    input  logic               branch_d,
    input  logic               jump_d,
    input  logic [1:0]         result_src_d,
    input  logic [1:0]         forward_a_e,
    input  logic [1:0]         forward_b_e,
    input  logic [XLEN-1:0]    result_w,
    output logic [RADDR_W-1:0] rs1_e,
    output logic [RADDR_W-1:0] rs2_e,
    output logic [RADDR_W-1:0] rd_e,
    output logic               pc_src_e,
    output logic [XLEN-1:0]    pc_target_e,
    output logic [XLEN-1:0]    alu_result_m,
    output logic [XLEN-1:0]    write_data_m,
    output logic [XLEN-1:0]    pc4_m,
    output logic [RADDR_W-1:0] rd_m,
    output logic               reg_write_m,
    output logic               mem_write_m,
    output logic [1:0]         result_src_m,
    output logic               illegal_alu_m
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    rd1;
        logic [XLEN-1:0]    rd2;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    pc4;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [RADDR_W-1:0] rd;
        logic [3:0]         alu_control;
        logic               alu_src;
        logic               reg_write;
        logic               mem_write;
        logic               branch;
        logic               jump;
        logic [1:0]         result_src;
    } idex_t;

    typedef struct packed {
        logic [XLEN-1:0]    alu_result;
        logic [XLEN-1:0]    write_data;
        logic [XLEN-1:0]    pc4;
        logic [RADDR_W-1:0] rd;
        logic               reg_write;
        logic               mem_write;
        logic [1:0]         result_src;
        logic               illegal;
    } exmem_t;

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            alu_illegal;

    // Reserved select 11 falls back to the register-file operand.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] w_val,
        input logic [XLEN-1:0] m_val
    );
        case (fwd_sel_e'(sel))
            FWD_W:   return w_val;
            FWD_M:   return m_val;
            default: return reg_val;
        endcase
    endfunction

    // ID/EX: flush beats stall; a flushed slot is an all-zero bubble with valid cleared.
    always_comb begin
        idex_d = idex_q;
        if (flush_e) begin
            idex_d = '0;
        end else if (!stall_e) begin
            idex_d = '{
                valid:       1'b1,
                rd1:         rd1_d,
                rd2:         rd2_d,
                imm:         imm_ext_d,
                pc:          pc_d,
                pc4:         pc4_d,
                rs1:         rs1_d,
                rs2:         rs2_d,
                rd:          rd_d,
                alu_control: alu_control_d,
                alu_src:     alu_src_d,
                reg_write:   reg_write_d,
                mem_write:   mem_write_d,
                branch:      branch_d,
                jump:        jump_d,
                result_src:  result_src_d
            };
        end
    end

    always_ff @(posedge clk) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign src_a     = fwd_operand(forward_a_e, idex_q.rd1, result_w, alu_result_m);
    assign src_b_fwd = fwd_operand(forward_b_e, idex_q.rd2, result_w, alu_result_m);
    assign src_b     = idex_q.alu_src ? idex_q.imm : src_b_fwd;

    alu_core #(.XLEN(XLEN)) u_alu (
        .a           (src_a),
        .b           (src_b),
        .alu_control (idex_q.alu_control),
        .result      (alu_result),
        .zero        (alu_zero),
        .illegal     (alu_illegal)
    );

    // An illegal op's forced-zero result must not masquerade as a taken beq.
    assign pc_src_e    = idex_q.valid &
                         (idex_q.jump | (idex_q.branch & alu_zero & ~alu_illegal));
    assign pc_target_e = idex_q.pc + idex_q.imm;

    assign rs1_e = idex_q.rs1;
    assign rs2_e = idex_q.rs2;
    assign rd_e  = idex_q.rd;

    // EX/MEM: loads every cycle; illegal ops drop their architectural writes.
    always_comb begin
        exmem_d = '{
            alu_result: alu_result,
            write_data: src_b_fwd,
            pc4:        idex_q.pc4,
            rd:         idex_q.rd,
            reg_write:  idex_q.reg_write & ~alu_illegal,
            mem_write:  idex_q.mem_write & ~alu_illegal,
            result_src: idex_q.result_src,
            illegal:    alu_illegal
        };
    end

    always_ff @(posedge clk) begin
        if (reset) exmem_q <= '0;
        else       exmem_q <= exmem_d;
    end

    assign alu_result_m  = exmem_q.alu_result;
    assign write_data_m  = exmem_q.write_data;
    assign pc4_m         = exmem_q.pc4;
    assign rd_m          = exmem_q.rd;
    assign reg_write_m   = exmem_q.reg_write;
    assign mem_write_m   = exmem_q.mem_write;
    assign result_src_m  = exmem_q.result_src;
    assign illegal_alu_m = exmem_q.illegal;

endmodule
